// File: rtl/nq_pkg.sv
// Shared NanoQuarter definitions: default widths, instruction field positions and the PC type.
package nq_pkg;

  localparam int unsigned NqInstW = 16;
  localparam int unsigned NqPcW   = 32;

  // Instruction field positions, shared with main_control and ALU_Control.
  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 14;
  localparam int unsigned Rs1Msb    = 13;
  localparam int unsigned Rs1Lsb    = 11;
  localparam int unsigned Rs2Msb    = 10;
  localparam int unsigned Rs2Lsb    = 8;
  localparam int unsigned RdMsb     = 7;
  localparam int unsigned RdLsb     = 5;

  typedef logic [NqPcW-1:0] pc_t;
  typedef logic [OpcodeMsb-OpcodeLsb:0] opcode_t;

  function automatic opcode_t opcode_of(input logic [NqInstW-1:0] inst);
    return inst[OpcodeMsb:OpcodeLsb];
  endfunction

endpackage

// File: rtl/nq_sync_fifo.sv
// Generic DEPTH x W synchronous ring buffer with flush, full/empty flags and entry count.
module nq_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch-to-decode instruction queue: buffers fetch words and issues one instruction per cycle
// with its PC, under decode stall, ready/valid back-pressure and branch flush.
module inst_prefetch_queue
  import nq_pkg::*;
#(
  parameter int unsigned INST_W  = NqInstW,
  parameter int unsigned SLOTS   = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = NqPcW,
  parameter int unsigned PC_STEP = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_valid,
  output logic                             fetch_ready,
  input  logic [INST_W*SLOTS-1:0]          fetch_word,
  input  logic [PC_W-1:0]                  fetch_pc,
  input  logic                             stall,
  input  logic                             flush,
  output logic                             inst_valid,
  output logic [INST_W-1:0]                inst,
  output logic [PC_W-1:0]                  inst_pc,
  output logic [$clog2(DEPTH*SLOTS+1)-1:0] inst_count
);

  localparam int unsigned WordW  = INST_W * SLOTS;
  localparam int unsigned EntryW = WordW + PC_W;
  localparam int unsigned SlotW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH * SLOTS + 1);
  localparam int unsigned FCntW  = $clog2(DEPTH + 1);

  logic [SlotW-1:0]  slot_ptr_q, slot_ptr_d;
  logic [EntryW-1:0] head_entry;
  logic [WordW-1:0]  head_word;
  logic [PC_W-1:0]   head_pc, pc_off;
  logic [FCntW-1:0]  entries;
  logic              fifo_full, fifo_empty;
  logic              push, pop_inst, slot_last;

  assign fetch_ready = rst & ~flush & ~fifo_full;
  assign push        = fetch_valid & fetch_ready;
  assign inst_valid  = rst & ~fifo_empty;
  assign pop_inst    = inst_valid & ~stall & ~flush;
  assign slot_last   = (slot_ptr_q == SlotW'(SLOTS - 1));

  nq_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop_inst & slot_last),
    .flush_i (flush),
    .wdata_i ({fetch_pc, fetch_word}),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (entries)
  );

  assign head_word = head_entry[WordW-1:0];
  assign head_pc   = head_entry[EntryW-1:WordW];
  assign pc_off    = PC_W'(slot_ptr_q) * PC_W'(PC_STEP);

  always_comb begin
    inst       = '0;
    inst_pc    = '0;
    inst_count = '0;
    if (inst_valid) begin
      inst    = head_word[slot_ptr_q*INST_W +: INST_W];
      inst_pc = head_pc + pc_off;
    end
    // The head entry is partly consumed by slot_ptr, so subtract the issued slots.
    if (rst) inst_count = CntW'(entries) * CntW'(SLOTS) - CntW'(slot_ptr_q);
  end

  always_comb begin
    slot_ptr_d = slot_ptr_q;
    if (flush) begin
      slot_ptr_d = '0;
    end else if (pop_inst) begin
      slot_ptr_d = slot_last ? '0 : slot_ptr_q + SlotW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_ptr_q <= '0;
    end else begin
      slot_ptr_q <= slot_ptr_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: per-instruction queue model plus directed checks.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_word;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        flush;
  logic        inst_valid;
  logic [15:0] inst;
  logic [31:0] inst_pc;
  logic [3:0]  inst_count;

  int n_tests = 0;
  int n_fail  = 0;

  inst_prefetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_word  (fetch_word),
    .fetch_pc    (fetch_pc),
    .stall       (stall),
    .flush       (flush),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_count  (inst_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flat list of buffered instructions; a word holds two, queue holds four words.
  logic [15:0] m_inst[$];
  logic [31:0] m_pc[$];

  function automatic int m_words();
    return (m_inst.size() + 1) / 2;
  endfunction

  function automatic logic m_ready();
    return rst && !flush && (m_words() < 4);
  endfunction

  always @(posedge clk) begin
    logic do_push, do_pop;
    do_push = fetch_valid && m_ready();
    do_pop  = rst && (m_inst.size() != 0) && !stall && !flush;
    if (!rst || flush) begin
      m_inst.delete();
      m_pc.delete();
    end else begin
      if (do_pop) begin
        void'(m_inst.pop_front());
        void'(m_pc.pop_front());
      end
      if (do_push) begin
        m_inst.push_back(fetch_word[15:0]);
        m_pc.push_back(fetch_pc);
        m_inst.push_back(fetch_word[31:16]);
        m_pc.push_back(fetch_pc + 32'd2);
      end
    end
  end

  always @(negedge clk) begin
    logic v;
    v = rst && (m_inst.size() != 0);
    check("model_ready", {31'd0, fetch_ready}, {31'd0, m_ready()});
    check("model_valid", {31'd0, inst_valid}, {31'd0, v});
    check("model_inst", {16'd0, inst}, v ? {16'd0, m_inst[0]} : 32'd0);
    check("model_pc", inst_pc, v ? m_pc[0] : 32'd0);
    check("model_count", {28'd0, inst_count}, rst ? m_inst.size() : 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; fetch_valid = 1'b1; fetch_word = 32'h1111_2222; fetch_pc = '0;
    stall = 1'b0; flush = 1'b0;

    // Reset held with fetch_valid high
    repeat (3) step();
    check("rst_ready", {31'd0, fetch_ready}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_count", {28'd0, inst_count}, 32'd0);
    rst = 1'b1; fetch_valid = 1'b0;
    #1 check("rel_ready", {31'd0, fetch_ready}, 32'd1);

    // Slot ordering
    fetch_valid = 1'b1; fetch_word = 32'hBBBB_AAAA; fetch_pc = 32'h100;
    step();
    fetch_valid = 1'b0;
    #1;
    check("ord_inst0", {16'd0, inst}, 32'hAAAA);
    check("ord_pc0", inst_pc, 32'h100);
    check("ord_cnt0", {28'd0, inst_count}, 32'd2);
    step();
    check("ord_inst1", {16'd0, inst}, 32'hBBBB);
    check("ord_pc1", inst_pc, 32'h102);
    step();
    check("ord_empty", {31'd0, inst_valid}, 32'd0);

    // Fill while stalled, then drain; three rounds to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
        fetch_valid = 1'b1;
        fetch_word  = {16'(16'h3001 + r * 256 + 2 * i), 16'(16'h3000 + r * 256 + 2 * i)};
        fetch_pc    = 32'h200 + r * 32'h40 + i * 4;
        step();
      end
      fetch_word = 32'hEEEE_EEEE; fetch_pc = 32'hE00;
      #1;
      check("fill_ready", {31'd0, fetch_ready}, 32'd0);
      check("fill_cnt", {28'd0, inst_count}, 32'd8);
      step();
      check("fill_5th", {28'd0, inst_count}, 32'd8);
      fetch_valid = 1'b0; stall = 1'b0;
      #1;
      for (int j = 0; j < 8; j++) begin
        check("drain_inst", {16'd0, inst}, 32'h3000 + r * 256 + j);
        check("drain_pc", inst_pc, 32'h200 + r * 32'h40 + (j / 2) * 4 + (j % 2) * 2);
        step();
      end
      check("drain_empty", {31'd0, inst_valid}, 32'd0);
    end

    // Full queue, head retires while a fetch is offered
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1; fetch_word = 32'h4000_0000 + i; fetch_pc = 32'h400 + i * 4;
      step();
    end
    fetch_valid = 1'b0; stall = 1'b0;
    step();
    check("sim_cnt7", {28'd0, inst_count}, 32'd7);
    fetch_valid = 1'b1; fetch_word = 32'h4444_5555; fetch_pc = 32'h480;
    #1 check("sim_noacc", {31'd0, fetch_ready}, 32'd0);
    step();
    check("sim_cnt6", {28'd0, inst_count}, 32'd6);
    check("sim_ready", {31'd0, fetch_ready}, 32'd1);
    step();
    check("sim_cnt7b", {28'd0, inst_count}, 32'd7);
    fetch_valid = 1'b0;

    // Flush with partially consumed head and a fetch offered
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_valid = 1'b1; fetch_word = 32'h8000_0000 + i; fetch_pc = 32'h800 + i * 4;
      step();
    end
    fetch_valid = 1'b0; stall = 1'b0;
    step();
    check("fl_cnt5", {28'd0, inst_count}, 32'd5);
    flush = 1'b1; fetch_valid = 1'b1; fetch_word = 32'hDEAD_BEEF; fetch_pc = 32'h900;
    #1 check("fl_ready", {31'd0, fetch_ready}, 32'd0);
    step();
    flush = 1'b0; fetch_valid = 1'b0;
    #1;
    check("fl_valid", {31'd0, inst_valid}, 32'd0);
    check("fl_cnt", {28'd0, inst_count}, 32'd0);
    fetch_valid = 1'b1; fetch_word = 32'h5555_4444; fetch_pc = 32'h700;
    step();
    fetch_valid = 1'b0;
    #1;
    check("fl_new_inst", {16'd0, inst}, 32'h4444);
    check("fl_new_pc", inst_pc, 32'h700);
    repeat (2) step();

    // PC wrap across slot offset
    fetch_valid = 1'b1; fetch_word = 32'h6666_7777; fetch_pc = 32'hFFFF_FFFE;
    step();
    fetch_valid = 1'b0;
    #1 check("wrap_pc0", inst_pc, 32'hFFFF_FFFE);
    step();
    check("wrap_inst1", {16'd0, inst}, 32'h6666);
    check("wrap_pc1", inst_pc, 32'h0000_0000);
    step();

    // Stall on an empty queue
    stall = 1'b1;
    repeat (2) step();
    check("stall_empty", {31'd0, inst_valid}, 32'd0);
    stall = 1'b0;

    // Reset mid-operation
    fetch_valid = 1'b1; fetch_word = 32'h9999_8888; fetch_pc = 32'hA00;
    step();
    fetch_valid = 1'b0;
    #1 check("mid_cnt", {28'd0, inst_count}, 32'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, fetch_ready}, 32'd0);
    check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    step();
    rst = 1'b1;
    #1;
    check("mid_post_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_post_cnt", {28'd0, inst_count}, 32'd0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
